// File: rtl/pcie_rx_cpld_reorder_pkg.sv
// Shared PCIe RX completion-reorder definitions.
// Holds the tag-slot and drain-FSM encodings, tag geometry and the constant
// upper bits of a granted tag.
package pcie_rx_cpld_reorder_pkg;

  localparam int unsigned C_TAG_NUM     = 8;
  localparam int unsigned C_TAG_W       = 3;
  localparam int unsigned C_TAG_FIELD_W = 8;
  localparam int unsigned C_TAG_PFX_W   = C_TAG_FIELD_W - C_TAG_W;

  // Upper bits of every tag this block hands out.
  localparam logic [C_TAG_PFX_W-1:0] C_TAG_PREFIX = '0;

  typedef enum logic [1:0] {
    SLOT_FREE = 2'd0,
    SLOT_PEND = 2'd1,
    SLOT_DONE = 2'd2
  } slot_state_e;

  typedef enum logic [1:0] {
    DRN_IDLE   = 2'd0,
    DRN_FETCH  = 2'd1,
    DRN_STREAM = 2'd2
  } drain_state_e;

  // Tag pointer increment with natural wrap 7 -> 0.
  function automatic logic [C_TAG_W-1:0] next_tag(input logic [C_TAG_W-1:0] ptr);
    return C_TAG_W'(ptr + 1'b1);
  endfunction

endpackage

// File: rtl/pcie_rx_cpld_reorder_if.sv
// Bus bundle of the completion reorder block.
//   cpld_fifo_*  : completion beats from the tag selector (master -> slave)
//   tag_alloc_*  : tag request / grant handshake
//   rd_*         : reordered output stream with valid/ready
//   cpld_err     : sticky error flag
// slave is the reorder block, master is its environment.
interface pcie_rx_cpld_reorder_if
  import pcie_rx_cpld_reorder_pkg::*;
#(
  parameter int unsigned C_PCIE_DATA_WIDTH = 512
) ();

  logic                         cpld_fifo_wr_en;
  logic [C_PCIE_DATA_WIDTH-1:0] cpld_fifo_wr_data;
  logic [C_TAG_FIELD_W-1:0]     cpld_fifo_tag;
  logic                         cpld_fifo_tag_last;

  logic                         tag_alloc_req;
  logic                         tag_alloc_ack;
  logic [C_TAG_FIELD_W-1:0]     tag_alloc_tag;

  logic                         rd_valid;
  logic                         rd_ready;
  logic [C_PCIE_DATA_WIDTH-1:0] rd_data;
  logic                         rd_last;

  logic                         cpld_err;

  modport slave (
    input  cpld_fifo_wr_en, cpld_fifo_wr_data, cpld_fifo_tag, cpld_fifo_tag_last,
    input  tag_alloc_req,
    output tag_alloc_ack, tag_alloc_tag,
    output rd_valid, rd_data, rd_last,
    input  rd_ready,
    output cpld_err
  );

  modport master (
    output cpld_fifo_wr_en, cpld_fifo_wr_data, cpld_fifo_tag, cpld_fifo_tag_last,
    output tag_alloc_req,
    input  tag_alloc_ack, tag_alloc_tag,
    input  rd_valid, rd_data, rd_last,
    output rd_ready,
    input  cpld_err
  );

endinterface

// File: rtl/pcie_rx_cpld_buf_ram.sv
// Completion beat buffer: simple dual-port RAM, one write port, one read
// port with a registered output that only updates when rd_en is high, so a
// stalled output beat stays put. No reset on storage or read register.
//   clk              : clock
//   wr_en/addr/data  : write port
//   rd_en/rd_addr    : read request, data appears the following cycle
//   rd_data          : registered read data
module pcie_rx_cpld_buf_ram #(
  parameter int unsigned C_DATA_W = 512,
  parameter int unsigned C_ADDR_W = 5
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic [C_ADDR_W-1:0] wr_addr,
  input  logic [C_DATA_W-1:0] wr_data,
  input  logic                rd_en,
  input  logic [C_ADDR_W-1:0] rd_addr,
  output logic [C_DATA_W-1:0] rd_data
);

  localparam int unsigned DEPTH = 1 << C_ADDR_W;

  logic [C_DATA_W-1:0] mem_q [DEPTH];
  logic [C_DATA_W-1:0] rd_data_q;

  // Storage write and registered read.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/pcie_rx_cpld_reorder.sv
// PCIe RX completion reorder buffer.
// Hands out tags 0..7 in order, collects completion beats per tag slot
// into a shared buffer and streams completed slots back out strictly in
// allocation order.
//   pcie_user_clk   : clock
//   pcie_user_rst_n : asynchronous active-low reset
//   bus (slave)     : completion input, tag allocation, output stream, error
module pcie_rx_cpld_reorder
  import pcie_rx_cpld_reorder_pkg::*;
#(
  parameter int unsigned C_PCIE_DATA_WIDTH = 512,
  parameter int unsigned C_SLOT_BEATS      = 4
) (
  input  logic                   pcie_user_clk,
  input  logic                   pcie_user_rst_n,
  pcie_rx_cpld_reorder_if.slave  bus
);

  localparam int unsigned BEAT_W = $clog2(C_SLOT_BEATS);
  localparam int unsigned CNT_W  = BEAT_W + 1;
  localparam int unsigned ADDR_W = C_TAG_W + BEAT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(C_SLOT_BEATS);

  slot_state_e        slot_st_q  [C_TAG_NUM];
  slot_state_e        slot_st_d  [C_TAG_NUM];
  logic [CNT_W-1:0]   slot_cnt_q [C_TAG_NUM];
  logic [CNT_W-1:0]   slot_cnt_d [C_TAG_NUM];

  logic [C_TAG_W-1:0] alloc_ptr_q, alloc_ptr_d;
  logic [C_TAG_W-1:0] rd_ptr_q,    rd_ptr_d;
  logic               ack_q,       ack_d;
  logic [C_TAG_W-1:0] ack_tag_q,   ack_tag_d;
  drain_state_e       drn_q,       drn_d;
  logic [BEAT_W-1:0]  rd_beat_q,   rd_beat_d;
  logic               rd_valid_q,  rd_valid_d;
  logic               rd_last_q,   rd_last_d;
  logic               err_q,       err_d;

  logic [C_TAG_W-1:0]  wr_tag_c;
  logic [CNT_W-1:0]    wr_cnt_c;
  logic                wr_pend_c;
  logic                wr_ok_c;
  logic [ADDR_W-1:0]   ram_waddr_c;
  logic [CNT_W-1:0]    rd_cnt_c;
  logic [C_TAG_W-1:0]  rd_ptr_nxt_c;
  logic [BEAT_W-1:0]   rd_beat_nxt_c;
  logic                ram_re_c;
  logic [ADDR_W-1:0]   ram_raddr_c;
  logic [C_PCIE_DATA_WIDTH-1:0] ram_rdata;
  logic                unused_tag_bits;

  // Only the low tag bits address a slot; the rest are carried but ignored.
  assign wr_tag_c        = bus.cpld_fifo_tag[C_TAG_W-1:0];
  assign unused_tag_bits = ^bus.cpld_fifo_tag[C_TAG_FIELD_W-1:C_TAG_W];

  // Write-side decode.
  assign wr_cnt_c    = slot_cnt_q[wr_tag_c];
  assign wr_pend_c   = (slot_st_q[wr_tag_c] == SLOT_PEND);
  assign wr_ok_c     = bus.cpld_fifo_wr_en && wr_pend_c && (wr_cnt_c < CNT_MAX);
  assign ram_waddr_c = {wr_tag_c, wr_cnt_c[BEAT_W-1:0]};

  // Drain-side helpers.
  assign rd_cnt_c      = slot_cnt_q[rd_ptr_q];
  assign rd_ptr_nxt_c  = next_tag(rd_ptr_q);
  assign rd_beat_nxt_c = BEAT_W'(rd_beat_q + 1'b1);

  // Next-state: allocation, write bookkeeping and drain FSM. The three
  // touch disjoint slots (FREE, PEND, DONE respectively), so they never
  // fight over a slot entry.
  always_comb begin
    slot_st_d   = slot_st_q;
    slot_cnt_d  = slot_cnt_q;
    alloc_ptr_d = alloc_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ack_d       = 1'b0;
    ack_tag_d   = ack_tag_q;
    drn_d       = drn_q;
    rd_beat_d   = rd_beat_q;
    rd_valid_d  = rd_valid_q;
    rd_last_d   = rd_last_q;
    err_d       = err_q;
    ram_re_c    = 1'b0;
    ram_raddr_c = {rd_ptr_q, rd_beat_q};

    // Tag grant; the ack_q term keeps a still-held request from double-granting.
    if (bus.tag_alloc_req && !ack_q && (slot_st_q[alloc_ptr_q] == SLOT_FREE)) begin
      ack_d                   = 1'b1;
      ack_tag_d               = alloc_ptr_q;
      slot_st_d[alloc_ptr_q]  = SLOT_PEND;
      slot_cnt_d[alloc_ptr_q] = '0;
      alloc_ptr_d             = next_tag(alloc_ptr_q);
    end

    // Completion beat bookkeeping; dropped beats still close a PEND slot.
    if (bus.cpld_fifo_wr_en) begin
      if (wr_ok_c) slot_cnt_d[wr_tag_c] = CNT_W'(wr_cnt_c + 1'b1);
      else         err_d = 1'b1;
      if (bus.cpld_fifo_tag_last && wr_pend_c) slot_st_d[wr_tag_c] = SLOT_DONE;
    end

    // In-order drain.
    unique case (drn_q)
      DRN_IDLE: begin
        if (slot_st_q[rd_ptr_q] == SLOT_DONE) begin
          if (rd_cnt_c == '0) begin
            slot_st_d[rd_ptr_q] = SLOT_FREE;
            rd_ptr_d            = rd_ptr_nxt_c;
          end else begin
            drn_d = DRN_FETCH;
          end
        end
      end
      DRN_FETCH: begin
        if (rd_cnt_c == '0) begin
          slot_st_d[rd_ptr_q] = SLOT_FREE;
          rd_ptr_d            = rd_ptr_nxt_c;
          drn_d               = DRN_IDLE;
        end else begin
          ram_re_c    = 1'b1;
          ram_raddr_c = {rd_ptr_q, BEAT_W'(0)};
          rd_beat_d   = '0;
          rd_valid_d  = 1'b1;
          rd_last_d   = (rd_cnt_c == CNT_W'(1));
          drn_d       = DRN_STREAM;
        end
      end
      DRN_STREAM: begin
        if (bus.rd_ready) begin
          if (rd_last_q) begin
            slot_st_d[rd_ptr_q]  = SLOT_FREE;
            slot_cnt_d[rd_ptr_q] = '0;
            rd_ptr_d             = rd_ptr_nxt_c;
            rd_valid_d           = 1'b0;
            rd_last_d            = 1'b0;
            drn_d = (slot_st_q[rd_ptr_nxt_c] == SLOT_DONE) ? DRN_FETCH : DRN_IDLE;
          end else begin
            // Prefetch the next beat so one beat per cycle is sustained.
            ram_re_c    = 1'b1;
            ram_raddr_c = {rd_ptr_q, rd_beat_nxt_c};
            rd_beat_d   = rd_beat_nxt_c;
            rd_last_d   = ((CNT_W'(rd_beat_q) + CNT_W'(2)) == rd_cnt_c);
          end
        end
      end
      default: drn_d = DRN_IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
    if (!pcie_user_rst_n) begin
      for (int i = 0; i < int'(C_TAG_NUM); i++) begin
        slot_st_q[i]  <= SLOT_FREE;
        slot_cnt_q[i] <= '0;
      end
      alloc_ptr_q <= '0;
      rd_ptr_q    <= '0;
      ack_q       <= 1'b0;
      ack_tag_q   <= '0;
      drn_q       <= DRN_IDLE;
      rd_beat_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      slot_st_q   <= slot_st_d;
      slot_cnt_q  <= slot_cnt_d;
      alloc_ptr_q <= alloc_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ack_q       <= ack_d;
      ack_tag_q   <= ack_tag_d;
      drn_q       <= drn_d;
      rd_beat_q   <= rd_beat_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      err_q       <= err_d;
    end
  end

  pcie_rx_cpld_buf_ram #(
    .C_DATA_W (C_PCIE_DATA_WIDTH),
    .C_ADDR_W (ADDR_W)
  ) u_buf_ram (
    .clk     (pcie_user_clk),
    .wr_en   (wr_ok_c),
    .wr_addr (ram_waddr_c),
    .wr_data (bus.cpld_fifo_wr_data),
    .rd_en   (ram_re_c),
    .rd_addr (ram_raddr_c),
    .rd_data (ram_rdata)
  );

  assign bus.tag_alloc_ack = ack_q;
  assign bus.tag_alloc_tag = {C_TAG_PREFIX, ack_tag_q};
  assign bus.rd_valid      = rd_valid_q;
  assign bus.rd_last       = rd_last_q;
  assign bus.rd_data       = ram_rdata;
  assign bus.cpld_err      = err_q;

endmodule

// File: tb/tb_pcie_rx_cpld_reorder.sv
// Self-checking bench for pcie_rx_cpld_reorder: a cycle table for the
// out-of-order completion case plus hand sequences for full/wrap, overflow,
// backpressure and reset-during-drain.
module tb_pcie_rx_cpld_reorder;

  localparam int unsigned DW = 64;

  logic clk;
  logic rst_n;

  pcie_rx_cpld_reorder_if #(.C_PCIE_DATA_WIDTH(DW)) bus ();

  pcie_rx_cpld_reorder #(
    .C_PCIE_DATA_WIDTH (DW),
    .C_SLOT_BEATS      (4)
  ) dut (
    .pcie_user_clk   (clk),
    .pcie_user_rst_n (rst_n),
    .bus             (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic          wr_en;
    logic [7:0]    tag;
    logic          last;
    logic [DW-1:0] data;
    logic          exp_valid;
    logic          exp_last;
    logic [DW-1:0] exp_data;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.cpld_fifo_wr_en    = 1'b0;
    bus.cpld_fifo_wr_data  = '0;
    bus.cpld_fifo_tag      = '0;
    bus.cpld_fifo_tag_last = 1'b0;
    bus.tag_alloc_req      = 1'b0;
    bus.rd_ready           = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    chk("rst_ack",   64'(bus.tag_alloc_ack), 64'd0);
    chk("rst_valid", 64'(bus.rd_valid),      64'd0);
    chk("rst_last",  64'(bus.rd_last),       64'd0);
    chk("rst_err",   64'(bus.cpld_err),      64'd0);
    rst_n = 1'b1;
  endtask

  // Request a tag and wait (bounded) for the grant.
  task automatic do_alloc(input logic [7:0] exp_tag);
    bit got;
    got = 1'b0;
    bus.tag_alloc_req = 1'b1;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (bus.tag_alloc_ack) begin
        got = 1'b1;
        chk("alloc_tag", 64'(bus.tag_alloc_tag), 64'(exp_tag));
      end
    end
    bus.tag_alloc_req = 1'b0;
    chk("alloc_ack", 64'(got), 64'd1);
  endtask

  task automatic write_burst(input logic [7:0] tag, input int n, input bit last_final,
                             input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.cpld_fifo_wr_en    = 1'b1;
      bus.cpld_fifo_tag      = tag;
      bus.cpld_fifo_tag_last = last_final && (i == n - 1);
      bus.cpld_fifo_wr_data  = base + DW'(i);
    end
    @(negedge clk);
    bus.cpld_fifo_wr_en    = 1'b0;
    bus.cpld_fifo_tag_last = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int idx;
    int vcyc;
    int acyc;
    int nack;
    logic [DW-1:0] exp4 [4];

    rst_n = 1'b0;
    idle_inputs();

    // Per-cycle table: inputs driven in a cycle, outputs observed in that cycle.
    vecs[0]  = '{1'b0, 8'h00, 1'b1, 64'h0,   1'b0, 1'b0, 64'h0};   // stray tag_last ignored
    vecs[1]  = '{1'b1, 8'h01, 1'b0, 64'h110, 1'b0, 1'b0, 64'h0};
    vecs[2]  = '{1'b1, 8'h09, 1'b0, 64'h111, 1'b0, 1'b0, 64'h0};   // upper tag bits ignored
    vecs[3]  = '{1'b1, 8'h01, 1'b1, 64'h112, 1'b0, 1'b0, 64'h0};
    vecs[4]  = '{1'b1, 8'h00, 1'b0, 64'h100, 1'b0, 1'b0, 64'h0};   // tag1 DONE but must wait
    vecs[5]  = '{1'b1, 8'h00, 1'b1, 64'h101, 1'b0, 1'b0, 64'h0};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 64'h0,   1'b0, 1'b0, 64'h0};   // tag0 DONE visible
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 64'h0,   1'b0, 1'b0, 64'h0};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 64'h0,   1'b1, 1'b0, 64'h100}; // two cycles after DONE
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 64'h0,   1'b1, 1'b1, 64'h101};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 64'h0,   1'b0, 1'b0, 64'h0};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 64'h0,   1'b1, 1'b0, 64'h110};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 64'h0,   1'b1, 1'b0, 64'h111};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 64'h0,   1'b1, 1'b1, 64'h112};
    vecs[14] = '{1'b0, 8'h00, 1'b0, 64'h0,   1'b0, 1'b0, 64'h0};
    vecs[15] = '{1'b0, 8'h00, 1'b0, 64'h0,   1'b0, 1'b0, 64'h0};

    // Out-of-order completion, in-order drain.
    do_reset();
    do_alloc(8'd0);
    do_alloc(8'd1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", i), 64'(bus.rd_valid), 64'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        chk($sformatf("tbl%0d_data", i), 64'(bus.rd_data), 64'(vecs[i].exp_data));
        chk($sformatf("tbl%0d_last", i), 64'(bus.rd_last), 64'(vecs[i].exp_last));
      end
      chk($sformatf("tbl%0d_err", i), 64'(bus.cpld_err), 64'd0);
      bus.cpld_fifo_wr_en    = vecs[i].wr_en;
      bus.cpld_fifo_tag      = vecs[i].tag;
      bus.cpld_fifo_tag_last = vecs[i].last;
      bus.cpld_fifo_wr_data  = vecs[i].data;
    end

    // All eight tags outstanding: ninth request waits for tag0 to drain.
    do_reset();
    for (int t = 0; t < 8; t++) do_alloc(8'(t));
    bus.tag_alloc_req = 1'b1;
    nack = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.tag_alloc_ack) nack++;
    end
    chk("full_no_ack", 64'(nack), 64'd0);
    write_burst(8'd0, 1, 1'b1, 64'h500);
    vcyc = -1;
    acyc = -1;
    for (int k = 2; k <= 12; k++) begin
      @(negedge clk);
      if (bus.rd_valid && vcyc < 0) begin
        vcyc = k;
        chk("full_rd_data", 64'(bus.rd_data), 64'h500);
        chk("full_rd_last", 64'(bus.rd_last), 64'd1);
      end
      if (bus.tag_alloc_ack && acyc < 0) begin
        acyc = k;
        chk("full_ack_tag", 64'(bus.tag_alloc_tag), 64'd0);
        bus.tag_alloc_req = 1'b0;
      end
    end
    bus.tag_alloc_req = 1'b0;
    chk("full_valid_cycle", 64'(vcyc), 64'd3);
    chk("full_ack_cycle",   64'(acyc), 64'd5);

    // Slot overflow: fifth beat dropped, error sticky.
    do_reset();
    do_alloc(8'd0);
    write_burst(8'd0, 4, 1'b0, 64'h700);
    chk("ovf_err_before", 64'(bus.cpld_err), 64'd0);
    write_burst(8'd0, 1, 1'b1, 64'h704);
    chk("ovf_err_set", 64'(bus.cpld_err), 64'd1);
    idx = 0;
    for (int c = 0; c < 30 && idx < 4; c++) begin
      @(negedge clk);
      if (bus.rd_valid) begin
        chk($sformatf("ovf_data%0d", idx), 64'(bus.rd_data), 64'h700 + 64'(idx));
        chk($sformatf("ovf_last%0d", idx), 64'(bus.rd_last), 64'(idx == 3));
        idx++;
      end
    end
    chk("ovf_beats", 64'(idx), 64'd4);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("ovf_no_extra", 64'(bus.rd_valid), 64'd0);
    end
    chk("ovf_err_sticky", 64'(bus.cpld_err), 64'd1);

    // Backpressure 1010 during a 4-beat drain.
    do_reset();
    do_alloc(8'd0);
    for (int i = 0; i < 4; i++) exp4[i] = 64'hC00 + DW'(i * 3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.cpld_fifo_wr_en    = 1'b1;
      bus.cpld_fifo_tag      = 8'd0;
      bus.cpld_fifo_tag_last = (i == 3);
      bus.cpld_fifo_wr_data  = exp4[i];
    end
    @(negedge clk);
    bus.cpld_fifo_wr_en    = 1'b0;
    bus.cpld_fifo_tag_last = 1'b0;
    idx = 0;
    for (int c = 0; c < 40 && idx < 4; c++) begin
      @(negedge clk);
      if (bus.rd_valid) begin
        chk($sformatf("bp_data%0d", idx), 64'(bus.rd_data), 64'(exp4[idx]));
        chk($sformatf("bp_last%0d", idx), 64'(bus.rd_last), 64'(idx == 3));
      end
      bus.rd_ready = (c % 2 == 0);
      if (bus.rd_valid && bus.rd_ready) idx++;
    end
    chk("bp_beats", 64'(idx), 64'd4);
    bus.rd_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("bp_no_dup", 64'(bus.rd_valid), 64'd0);
    end

    // Reset while streaming.
    do_reset();
    do_alloc(8'd0);
    bus.rd_ready = 1'b0;
    write_burst(8'd0, 4, 1'b1, 64'hE00);
    vcyc = 0;
    for (int c = 0; c < 20 && vcyc == 0; c++) begin
      @(negedge clk);
      if (bus.rd_valid) vcyc = 1;
    end
    chk("mid_valid_seen", 64'(vcyc), 64'd1);
    chk("mid_beat0", 64'(bus.rd_data), 64'hE00);
    bus.rd_ready = 1'b1;
    @(negedge clk);
    bus.rd_ready = 1'b0;
    chk("mid_beat1_valid", 64'(bus.rd_valid), 64'd1);
    chk("mid_beat1", 64'(bus.rd_data), 64'hE01);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.rd_valid), 64'd0);
    chk("mid_rst_last",  64'(bus.rd_last),  64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.rd_ready = 1'b1;
    do_alloc(8'd0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("post_rst_idle", 64'(bus.rd_valid), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
